mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined RV32I core, between the EX/MEM register and `mem_wb`. Runs loads and stores against a handshaked data memory, stalls upstream while an access is outstanding, and returns the aligned, sign- or zero-extended load data. Produces the `wb_data`/`inst` pair that `mem_wb` registers: ALU result, load data, or PC+4 for jumps. Emits a NOP bubble whenever no instruction completes.

## Interface
- `DATA_WIDTH`, 32: datapath and instruction width.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `valid_i`  in  1  EX/MEM holds a valid instruction.
- `inst_i`  in  32  instruction from EX/MEM.
- `pc_i`  in  32  PC of `inst_i`.
- `alu_data_i`  in  32  ALU result or effective address.
- `rs2_data_i`  in  32  store data.
- `stall_o`  out  1  upstream must hold its outputs at the next edge.
- `dmem_req_o`  out  1  memory request, held until ack.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_wdata_o`  out  32  lane-replicated store data.
- `dmem_be_o`  out  4  byte enables; 0 for loads.
- `dmem_ack_i`  in  1  access complete; read data valid this cycle.
- `dmem_rdata_i`  in  32  read word.
- `wb_data_o`  out  32  write-back data to `mem_wb`.
- `inst_o`  out  32  instruction to `mem_wb`; bubble = `32'h0000_0013`.
- `fault_o`  out  1  one-cycle pulse for a misaligned or illegal memory op.

## Operation
- Decode uses `opcode = inst[6:2]` and `funct3 = inst[14:12]`.
  - Opcode 00000 is a load, 01000 a store, 11011/11001 are JAL/JALR.
  - Everything else is ALU-class.
- Width is set by funct3:
  - 000: byte (B); 001: half (H); 010: word (W).
  - 100: byte unsigned (BU); 101: half unsigned (HU).
  - Any other funct3 on a load, or funct3 > 010 on a store, is illegal.
- A memory op is misaligned when:
  - H/HU and `addr[0]` = 1, or
  - W and `addr[1:0]` ≠ 0.
- States: IDLE, REQ.
- IDLE, `valid_i` = 0: `inst_o` = bubble, `wb_data_o` = 0, `stall_o` = 0.
- IDLE, ALU-class: pass through combinationally, zero latency.
  - `inst_o` = `inst_i`, `wb_data_o` = `alu_data_i`.
  - JAL/JALR instead give `wb_data_o` = `pc_i`+4, modulo 2^32.
- IDLE, misaligned or illegal memory op:
  - No memory access, `fault_o` = 1, output bubble, `stall_o` = 0, stay IDLE.
- IDLE, legal memory op:
  - Latch inst, address, write data and byte enables.
  - Output bubble, `stall_o` = 1, go to REQ.
- REQ:
  - `dmem_req_o` = 1. Address, we, wdata and be come from the latches and stay stable.
  - Without ack: `stall_o` = 1, output bubble, stay in REQ.
  - With ack: `stall_o` = 0, `inst_o` = latched inst, go to IDLE.
    - Load: `wb_data_o` = extended load data.
    - Store: `wb_data_o` = 0.
- Store lanes:
  - SB: `be` = `4'b0001 << addr[1:0]`, `wdata` = `{4{rs2[7:0]}}`.
  - SH: `be` = `addr[1] ? 4'b1100 : 4'b0011`, `wdata` = `{2{rs2[15:0]}}`.
  - SW: `be` = `4'b1111`, `wdata` = rs2.
- Load extraction: select the byte or half at `addr[1:0]` from `dmem_rdata_i`.
  - B and H sign-extend; BU and HU zero-extend.
- `dmem_ack_i` is ignored in IDLE.

## Timing
- Reset:
  - State goes to IDLE at the edge.
  - While `rst_i` is high, all outputs are forced: `dmem_req_o`=0, `stall_o`=0, `fault_o`=0, `inst_o`=bubble, `wb_data_o`=0, `dmem_be_o`=0.
- Reset during REQ aborts the access: `dmem_req_o` is low from the reset cycle onward.
- Memory op with ack on the first REQ cycle: one stall cycle, and the instruction completes on the second cycle.
- Each additional cycle without ack adds one stall cycle.
- `stall_o` and the output mux are combinational from `state`, `valid_i`, the decode and `dmem_ack_i`. No combinational path runs from `dmem_rdata_i` to `stall_o`.
- Back-to-back memory ops: the instruction after a completed access appears in IDLE and may stall again immediately. No dead cycle is required.
- `fault_o` is asserted only in IDLE, for exactly one cycle per faulting instruction.

## Test plan
- Reset for 2 cycles, then `valid_i`=0 → `inst_o`=0x00000013, `wb_data_o`=0, `dmem_req_o`=0, `stall_o`=0.
- ADD with `alu_data_i`=0x1234, then JAL with `pc_i`=0x100 → same-cycle `wb_data_o` of 0x1234, then 0x104, with no stall.
- LB at addr 0x1003, `rdata`=0x80xxxxxx, ack on the first REQ cycle → 1 bubble, then `wb_data_o`=0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH at addr 0x2002, `rs2`=0xABCD1234, ack after 3 REQ cycles → `stall_o` high for 4 cycles, with `dmem_addr_o`=0x2000, `be`=1100 and `wdata`=0x12341234 held stable throughout.
- LW at addr 0x3001 → `fault_o` pulses, no `dmem_req_o`, bubble output; the next ADD passes with no stall.
- `rst_i` asserted on the second REQ cycle of an LW → `dmem_req_o`=0 and state IDLE after the edge. A late ack is ignored and the output is a bubble.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV32I pipeline.
//
// Sits between the EX/MEM register and mem_wb. ALU-class instructions pass through
// combinationally. Loads and stores are latched and issued to a handshaked data memory
// while upstream is stalled. Misaligned or illegal memory ops raise a one-cycle fault
// and produce a bubble.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   valid_i, inst_i     instruction from EX/MEM and its valid flag
//   pc_i                PC of inst_i (used for the JAL/JALR link value)
//   alu_data_i          ALU result or effective address
//   rs2_data_i          store data
//   stall_o             upstream must hold its outputs at the next edge
//   dmem_*              request/ack data-memory port (word address, byte enables)
//   wb_data_o, inst_o   write-back data and instruction to mem_wb (bubble = addi x0,x0,0)
//   fault_o             one-cycle pulse for a misaligned or illegal memory op
module mem_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] inst_i,
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic [DATA_WIDTH-1:0] alu_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   output logic                  stall_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [DATA_WIDTH-1:0] dmem_addr_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   output logic [3:0]            dmem_be_o,
   input  logic                  dmem_ack_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic                  fault_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   localparam logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h0000_0013);

   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_JAL   = 5'b11011;
   localparam logic [4:0] OP_JALR  = 5'b11001;

   logic [0:0]            r_state;
   logic [0:0]            w_state_next;
   logic [DATA_WIDTH-1:0] r_inst;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_be;
   logic                  r_we;

   logic [4:0]            w_opcode;
   logic [2:0]            w_funct3;
   logic                  w_is_load;
   logic                  w_is_store;
   logic                  w_is_jump;
   logic                  w_illegal;
   logic                  w_misaligned;
   logic                  w_fault;
   logic                  w_mem_go;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;

   logic [DATA_WIDTH-1:0] w_shifted;
   logic [7:0]            w_ld_byte;
   logic [15:0]           w_ld_half;
   logic [DATA_WIDTH-1:0] w_ld_data;

   // Decode of the incoming instruction; only meaningful in IDLE.
   always_comb begin
      w_opcode   = inst_i[6:2];
      w_funct3   = inst_i[14:12];
      w_is_load  = (w_opcode == OP_LOAD);
      w_is_store = (w_opcode == OP_STORE);
      w_is_jump  = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);

      w_illegal = 1'b0;
      if (w_is_load) begin
         case (w_funct3)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default:                w_illegal = 1'b0;
         endcase
      end else if (w_is_store) begin
         w_illegal = (w_funct3 > 3'b010);
      end

      case (w_funct3)
         3'b001, 3'b101: w_misaligned = alu_data_i[0];
         3'b010:         w_misaligned = |alu_data_i[1:0];
         default:        w_misaligned = 1'b0;
      endcase

      w_fault  = valid_i && (w_is_load || w_is_store) && (w_illegal || w_misaligned);
      w_mem_go = valid_i && (w_is_load || w_is_store) && !(w_illegal || w_misaligned);
   end

   // Store lane placement; loads latch zero byte enables.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = rs2_data_i;
      if (w_is_store) begin
         case (w_funct3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << alu_data_i[1:0];
               w_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
               w_be    = alu_data_i[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{rs2_data_i[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = rs2_data_i;
            end
         endcase
      end
   end

   // Load extraction from the latched width and byte offset.
   always_comb begin
      w_shifted = dmem_rdata_i >> {r_addr[1:0], 3'b000};
      w_ld_byte = w_shifted[7:0];
      w_ld_half = r_addr[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (r_inst[14:12])
         3'b000:  w_ld_data = {{(DATA_WIDTH-8){w_ld_byte[7]}}, w_ld_byte};
         3'b100:  w_ld_data = {{(DATA_WIDTH-8){1'b0}}, w_ld_byte};
         3'b001:  w_ld_data = {{(DATA_WIDTH-16){w_ld_half[15]}}, w_ld_half};
         3'b101:  w_ld_data = {{(DATA_WIDTH-16){1'b0}}, w_ld_half};
         default: w_ld_data = dmem_rdata_i;
      endcase
   end

   // Outputs and next state. Reset overrides everything so an in-flight request drops
   // in the same cycle reset is seen.
   always_comb begin
      w_state_next = r_state;
      stall_o      = 1'b0;
      fault_o      = 1'b0;
      dmem_req_o   = 1'b0;
      inst_o       = NOP_INST;
      wb_data_o    = '0;

      if (!rst_i) begin
         case (r_state)
            ST_IDLE: begin
               if (valid_i) begin
                  if (w_fault) begin
                     fault_o = 1'b1;
                  end else if (w_mem_go) begin
                     stall_o      = 1'b1;
                     w_state_next = ST_REQ;
                  end else begin
                     inst_o    = inst_i;
                     wb_data_o = w_is_jump ? (pc_i + DATA_WIDTH'(4)) : alu_data_i;
                  end
               end
            end
            default: begin
               dmem_req_o = 1'b1;
               if (dmem_ack_i) begin
                  inst_o       = r_inst;
                  wb_data_o    = r_we ? '0 : w_ld_data;
                  w_state_next = ST_IDLE;
               end else begin
                  stall_o = 1'b1;
               end
            end
         endcase
      end
   end

   assign dmem_we_o    = dmem_req_o & r_we;
   assign dmem_be_o    = dmem_req_o ? r_be : 4'b0000;
   assign dmem_addr_o  = {r_addr[DATA_WIDTH-1:2], 2'b00};
   assign dmem_wdata_o = r_wdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_inst  <= NOP_INST;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= 4'b0000;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == ST_IDLE) && w_mem_go) begin
            r_inst  <= inst_i;
            r_addr  <= alu_data_i;
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_we    <= w_is_store;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic [31:0] inst_i, pc_i, alu_data_i, rs2_data_i;
   logic        stall_o, dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] wb_data_o, inst_o;
   logic        fault_o;

   always #5 clk = ~clk;

   mem_stage #(.DATA_WIDTH(32)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .inst_i       (inst_i),
      .pc_i         (pc_i),
      .alu_data_i   (alu_data_i),
      .rs2_data_i   (rs2_data_i),
      .stall_o      (stall_o),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_be_o    (dmem_be_o),
      .dmem_ack_i   (dmem_ack_i),
      .dmem_rdata_i (dmem_rdata_i),
      .wb_data_o    (wb_data_o),
      .inst_o       (inst_o),
      .fault_o      (fault_o)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] wb;
      logic        fault;
   } out_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   out_t exp_q[$];
   req_t req_q[$];

   // Reference memory is byte-addressed; the responder's memory is word-addressed.
   logic [7:0]  ref_b [256];
   logic [31:0] dmem  [64];

   int  n_tests = 0;
   int  n_fail  = 0;
   int  force_lat = 0;
   bit  late_ack  = 0;
   bit  mon_en    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op7, input logic [2:0] f3);
      return {17'h0, f3, 5'd10, op7};
   endfunction

   // Behavioural model: computes the response, the expected memory request and the
   // number of stall cycles for a given memory latency.
   task automatic model_issue(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] alu, input logic [31:0] rs2,
                              input int lat, output int exp_stalls);
      logic [4:0]  op;
      logic [2:0]  f3;
      int          size, base, off;
      bit          is_ld, is_st, legal;
      out_t        o;
      req_t        r;
      logic [31:0] v;
      op    = inst[6:2];
      f3    = inst[14:12];
      is_ld = (op == 5'b00000);
      is_st = (op == 5'b01000);
      o.inst  = inst;
      o.fault = 1'b0;
      o.wb    = alu;
      exp_stalls = 0;
      if (op == 5'b11011 || op == 5'b11001) o.wb = pc + 32'd4;
      if (is_ld || is_st) begin
         case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
         endcase
         legal = (size != 0) && !(is_st && f3 > 3'd2);
         off   = int'(alu[1:0]);
         if (legal) legal = (off % size) == 0;
         if (!legal) begin
            o.inst  = NOP;
            o.wb    = 32'h0;
            o.fault = 1'b1;
         end else begin
            base       = int'(alu[7:0]);
            exp_stalls = lat + 1;
            r.addr  = {alu[31:2], 2'b00};
            r.we    = is_st;
            r.be    = 4'b0000;
            r.wdata = 32'h0;
            if (is_st) begin
               for (int i = 0; i < 4; i++) begin
                  if (i >= off && i < off + size) r.be[i] = 1'b1;
                  r.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
               end
               for (int k = 0; k < size; k++) ref_b[base + k] = rs2[8*k +: 8];
               o.wb = 32'h0;
            end else begin
               v = 32'h0;
               for (int k = 0; k < size; k++) v[8*k +: 8] = ref_b[base + k];
               if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
               if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
               o.wb = v;
            end
            req_q.push_back(r);
         end
      end
      exp_q.push_back(o);
   endtask

   // Presents one instruction (entered at posedge+1) and holds it while stalled.
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] rs2, input int lat);
      int stalls, exp_stalls;
      model_issue(inst, pc, alu, rs2, lat, exp_stalls);
      force_lat  = lat;
      valid_i    = 1'b1;
      inst_i     = inst;
      pc_i       = pc;
      alu_data_i = alu;
      rs2_data_i = rs2;
      stalls     = 0;
      forever begin
         @(negedge clk);
         if (!stall_o) break;
         stalls++;
         if (stalls > 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall_timeout: inst %h still stalled after %0d cycles", inst, stalls);
            break;
         end
         @(posedge clk);
         #1;
      end
      check("stall_cycles", stalls, exp_stalls);
      @(posedge clk);
      #1;
      valid_i    = 1'b0;
      inst_i     = $urandom;
      pc_i       = $urandom;
      alu_data_i = $urandom;
      rs2_data_i = $urandom;
   endtask

   // Memory responder: checks each request against the model and acks after force_lat
   // wait cycles; throws spurious acks while idle.
   bit   in_req = 0;
   int   wait_cnt = 0;
   req_t cap;
   req_t ereq;
   always @(posedge clk) begin
      #2;
      if (dmem_req_o) begin
         if (!in_req) begin
            in_req   = 1;
            wait_cnt = 0;
            cap.addr = dmem_addr_o;
            cap.we   = dmem_we_o;
            cap.be   = dmem_be_o;
            cap.wdata = dmem_wdata_o;
            if (req_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_req: addr %h we %b, expected no request",
                        dmem_addr_o, dmem_we_o);
            end else begin
               ereq = req_q.pop_front();
               check("req_addr", dmem_addr_o, ereq.addr);
               check("req_we", 32'(dmem_we_o), 32'(ereq.we));
               check("req_be", 32'(dmem_be_o), 32'(ereq.be));
               if (ereq.we) check("req_wdata", dmem_wdata_o, ereq.wdata);
            end
         end else begin
            check("stable_addr", dmem_addr_o, cap.addr);
            check("stable_be", 32'(dmem_be_o), 32'(cap.be));
            check("stable_wdata", dmem_wdata_o, cap.wdata);
            check("stable_we", 32'(dmem_we_o), 32'(cap.we));
         end
         if (wait_cnt >= force_lat) begin
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = dmem[dmem_addr_o[7:2]];
            if (dmem_we_o) begin
               for (int i = 0; i < 4; i++)
                  if (dmem_be_o[i]) dmem[dmem_addr_o[7:2]][8*i +: 8] = dmem_wdata_o[8*i +: 8];
            end
            in_req = 0;
         end else begin
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = $urandom;
            wait_cnt++;
         end
      end else begin
         in_req       = 0;
         dmem_ack_i   = late_ack | ($urandom_range(0, 3) == 0);
         dmem_rdata_i = $urandom;
      end
   end

   // Monitor: any non-bubble output or fault pulse consumes one scoreboard entry.
   out_t mo;
   always @(negedge clk) begin
      if (mon_en && !rst_i) begin
         if (fault_o || inst_o !== NOP) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: inst %h wb %h fault %b, expected bubble",
                        inst_o, wb_data_o, fault_o);
            end else begin
               mo = exp_q.pop_front();
               check("out_inst", inst_o, mo.inst);
               check("out_wb", wb_data_o, mo.wb);
               check("out_fault", 32'(fault_o), 32'(mo.fault));
               if (fault_o) begin
                  check("fault_no_req", 32'(dmem_req_o), 32'h0);
                  check("fault_no_stall", 32'(stall_o), 32'h0);
               end
            end
         end else begin
            check("bubble_wb", wb_data_o, 32'h0);
         end
      end
   end

   initial begin
      logic [31:0] ri, ra;
      logic [2:0]  f3;
      logic [4:0]  op;
      int          cls;

      for (int b = 0; b < 256; b++) ref_b[b] = 8'($urandom);
      for (int w = 0; w < 64; w++)
         dmem[w] = {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};

      rst_i        = 1'b1;
      valid_i      = 1'b0;
      inst_i       = 32'h0;
      pc_i         = 32'h0;
      alu_data_i   = 32'h0;
      rs2_data_i   = 32'h0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;

      // Outputs forced while reset is held
      @(negedge clk);
      check("rst_req", 32'(dmem_req_o), 32'h0);
      check("rst_stall", 32'(stall_o), 32'h0);
      check("rst_fault", 32'(fault_o), 32'h0);
      check("rst_inst", inst_o, NOP);
      check("rst_wb", wb_data_o, 32'h0);
      check("rst_be", 32'(dmem_be_o), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("idle_inst", inst_o, NOP);
      check("idle_wb", wb_data_o, 32'h0);
      check("idle_req", 32'(dmem_req_o), 32'h0);
      check("idle_stall", 32'(stall_o), 32'h0);
      mon_en = 1;
      @(posedge clk);
      #1;

      // ADD then JAL, no stall
      issue(mk(7'b0110011, 3'b000), 32'h0000_0200, 32'h0000_1234, 32'h0, 0);
      issue(mk(7'b1101111, 3'b000), 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);

      // LB / LBU at 0x1003 with top byte 0x80
      ref_b[3]       = 8'h80;
      dmem[0][31:24] = 8'h80;
      issue(mk(7'b0000011, 3'b000), 32'h0, 32'h0000_1003, 32'h0, 0);
      issue(mk(7'b0000011, 3'b100), 32'h0, 32'h0000_1003, 32'h0, 0);

      // SH at 0x2002, three wait cycles
      issue(mk(7'b0100011, 3'b001), 32'h0, 32'h0000_2002, 32'hABCD_1234, 3);
      // Read back the halfword just stored
      issue(mk(7'b0000011, 3'b101), 32'h0, 32'h0000_2002, 32'h0, 1);

      // Misaligned LW faults, following ADD passes
      issue(mk(7'b0000011, 3'b010), 32'h0, 32'h0000_3001, 32'h0, 0);
      issue(mk(7'b0110011, 3'b000), 32'h0, 32'h0000_5555, 32'h0, 0);

      // Reset on the second REQ cycle of an LW aborts the access
      req_q.push_back('{addr: 32'h0000_0040, we: 1'b0, be: 4'b0000, wdata: 32'h0});
      force_lat  = 100;
      valid_i    = 1'b1;
      inst_i     = mk(7'b0000011, 3'b010);
      alu_data_i = 32'h0000_0040;
      @(negedge clk);
      check("abort_idle_stall", 32'(stall_o), 32'h1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("abort_req_before_rst", 32'(dmem_req_o), 32'h1);
      rst_i = 1'b1;
      @(negedge clk);
      check("abort_req", 32'(dmem_req_o), 32'h0);
      check("abort_stall", 32'(stall_o), 32'h0);
      check("abort_inst", inst_o, NOP);
      check("abort_be", 32'(dmem_be_o), 32'h0);
      @(posedge clk);
      #1;
      rst_i    = 1'b0;
      valid_i  = 1'b0;
      late_ack = 1;
      @(negedge clk);
      check("late_ack_req", 32'(dmem_req_o), 32'h0);
      check("late_ack_inst", inst_o, NOP);
      check("late_ack_stall", 32'(stall_o), 32'h0);
      check("late_ack_wb", wb_data_o, 32'h0);
      @(posedge clk);
      #1;
      late_ack  = 0;
      force_lat = 0;

      // Randomized mix
      for (int n = 0; n < 300; n++) begin
         cls = $urandom_range(0, 5);
         f3  = 3'($urandom);
         case (cls)
            0, 1: begin
               op = 5'($urandom);
               if (op == 5'b00000 || op == 5'b01000 || op == 5'b11011 || op == 5'b11001)
                  op = 5'b01100;
            end
            2:       op = 5'b00000;
            3:       op = 5'b01000;
            4:       op = 5'b11011;
            default: op = 5'b11001;
         endcase
         ri = {15'($urandom), 2'($urandom), f3, 5'($urandom), op, 2'b11};
         if (ri == NOP) ri[7] = 1'b1;
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'b01) ra[0] = 1'b0;
            if (f3[1:0] == 2'b10) ra[1:0] = 2'b00;
         end
         issue(ri, $urandom, ra, $urandom, $urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      check("exp_q_drained", exp_q.size(), 32'h0);
      check("req_q_drained", req_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
